// File: rtl/btn_bram_read_ctrl.sv
// Push-button driven BRAM read sequencer.
// Each button is synchronised and debounced. A debounced rising edge becomes a read request,
// and the lowest-index request wins. The controller issues one BRAM read, waits the read
// latency, then captures the word onto the LEDs and holds it there.
module btn_bram_read_ctrl #(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned ADDR_BASE    = 0,
    parameter int unsigned RD_LAT       = 2,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N_BTN-1:0]  btn_i,
    output logic              bram_en_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    input  logic [DATA_W-1:0] bram_dout_i,
    output logic [DATA_W-1:0] leds_o,
    output logic              rd_valid_o,
    output logic              busy_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned IdxW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int unsigned LatW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

    logic [N_BTN-1:0]  sync1_q, sync2_q;
    logic [N_BTN-1:0]  deb_q, deb_d;
    logic [N_BTN-1:0]  press_q, press_d;
    logic [CntW-1:0]   cnt_q [N_BTN];
    logic [CntW-1:0]   cnt_d [N_BTN];

    logic              any_press;
    logic [IdxW-1:0]   win_idx;
    logic [ADDR_W-1:0] issue_addr;

    state_e            state_q;
    logic [LatW-1:0]   lat_q;
    logic              bram_en_q, rd_valid_q, busy_q;
    logic [ADDR_W-1:0] bram_addr_q;
    logic [DATA_W-1:0] leds_q;

    // Two-flop synchroniser on the raw button levels.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count cycles of disagreement and flip the level once the count is reached.
    always_comb begin
        deb_d   = deb_q;
        press_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CntW'(DEBOUNCE_CYC - 1)) begin
                    deb_d[i]   = ~deb_q[i];
                    // Only a 0->1 flip is a press; releases produce nothing.
                    press_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state and the one-cycle press pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deb_q   <= '0;
            press_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q   <= deb_d;
            press_q <= press_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Fixed-priority pick: scanning downwards leaves the lowest asserted index.
    always_comb begin
        any_press = |press_q;
        win_idx   = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (press_q[i]) begin
                win_idx = IdxW'(i);
            end
        end
    end

    // Address wraps modulo 2^ADDR_W.
    assign issue_addr = ADDR_W'(ADDR_BASE + 32'(win_idx));

    // Read sequencer; all outputs are registered and set on entry to the state that owns them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            lat_q       <= '0;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            leds_q      <= '0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            bram_en_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (any_press) begin
                        state_q     <= StIssue;
                        bram_en_q   <= 1'b1;
                        bram_addr_q <= issue_addr;
                        busy_q      <= 1'b1;
                    end
                end
                StIssue: begin
                    if (RD_LAT == 1) begin
                        state_q <= StCapture;
                    end else begin
                        state_q <= StWait;
                        lat_q   <= LatW'(1);
                    end
                end
                StWait: begin
                    if (lat_q == LatW'(RD_LAT - 1)) begin
                        state_q <= StCapture;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                StCapture: begin
                    leds_q     <= bram_dout_i;
                    rd_valid_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bram_en_o   = bram_en_q;
    assign bram_addr_o = bram_addr_q;
    assign leds_o      = leds_q;
    assign rd_valid_o  = rd_valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_btn_bram_read_ctrl.sv
// Scoreboard bench for btn_bram_read_ctrl. Two instances (ADDR_BASE 0 and 14) share the buttons.
// A reference model predicts each read (cycle, address, data). A monitor checks every bram_en
// and rd_valid pulse against that prediction.
module tb_btn_bram_read_ctrl;

    localparam int DEB = 4;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'b0;
    logic       en_a, en_b, rv_a, rv_b, busy_a, busy_b;
    logic [3:0] addr_a, addr_b, dout_a, dout_b, leds_a, leds_b;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    btn_bram_read_ctrl #(
        .N_BTN(4), .ADDR_W(4), .DATA_W(4), .ADDR_BASE(0), .RD_LAT(LAT), .DEBOUNCE_CYC(DEB)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .btn_i(btn), .bram_en_o(en_a), .bram_addr_o(addr_a),
        .bram_dout_i(dout_a), .leds_o(leds_a), .rd_valid_o(rv_a), .busy_o(busy_a)
    );

    btn_bram_read_ctrl #(
        .N_BTN(4), .ADDR_W(4), .DATA_W(4), .ADDR_BASE(14), .RD_LAT(LAT), .DEBOUNCE_CYC(DEB)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .btn_i(btn), .bram_en_o(en_b), .bram_addr_o(addr_b),
        .bram_dout_i(dout_b), .leds_o(leds_b), .rd_valid_o(rv_b), .busy_o(busy_b)
    );

    // BRAM models: mem[a] = a ^ 4'hA, two-cycle read latency.
    logic [3:0] pa1 = 4'h0, pa2 = 4'h0, pb1 = 4'h0, pb2 = 4'h0;
    always @(posedge clk) begin
        if (en_a) pa1 <= addr_a ^ 4'hA;
        if (en_b) pb1 <= addr_b ^ 4'hA;
        pa2 <= pa1;
        pb2 <= pb1;
    end
    assign dout_a = pa2;
    assign dout_b = pb2;

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {int cyc; logic [3:0] a; logic [3:0] b;} exp_t;
    exp_t q_en[$];
    exp_t q_rv[$];

    // Reference model, evaluated once per clock edge.
    bit [3:0] m_s1, m_s2, m_deb, m_press;
    int       m_run[4];
    int       free_at = 0;

    task automatic model_step();
        int w;
        logic [3:0] wa, wb;
        cyc++;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; free_at = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            q_en.delete();
            q_rv.delete();
            return;
        end
        m_press = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i] = ~m_deb[i];
                    m_run[i] = 0;
                    m_press[i] = m_deb[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = btn;
        // Press pulse in this cycle; accepted only when the controller is idle.
        if (m_press != 0 && cyc >= free_at) begin
            w = 0;
            for (int i = 3; i >= 0; i--) if (m_press[i]) w = i;
            wa = 4'(w);
            wb = 4'((14 + w) % 16);
            q_en.push_back('{cyc + 1, wa, wb});
            q_rv.push_back('{cyc + LAT + 2, wa ^ 4'hA, wb ^ 4'hA});
            free_at = cyc + LAT + 2;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: pops expectations whenever a DUT presents a read or a result.
    int         en_cnt = 0, rv_cnt = 0, last_en_cyc = 0, last_rv_cyc = 0;
    logic [3:0] last_addr_a = 0, last_addr_b = 0;
    exp_t       e;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            while (q_en.size() > 0 && q_en[0].cyc < cyc) begin
                chk("en_missing", cyc, q_en[0].cyc);
                void'(q_en.pop_front());
            end
            while (q_rv.size() > 0 && q_rv[0].cyc < cyc) begin
                chk("rv_missing", cyc, q_rv[0].cyc);
                void'(q_rv.pop_front());
            end
            if (en_a || en_b) begin
                en_cnt++;
                last_en_cyc = cyc;
                last_addr_a = addr_a;
                last_addr_b = addr_b;
                chk("en_expected", int'(q_en.size() > 0), 1);
                if (q_en.size() > 0) begin
                    e = q_en.pop_front();
                    chk("en_cycle", cyc, e.cyc);
                    chk("en_both", int'(en_a && en_b), 1);
                    chk("addr_a", addr_a, e.a);
                    chk("addr_b", addr_b, e.b);
                    chk("busy_at_issue", busy_a, 1);
                end
            end
            if (rv_a || rv_b) begin
                rv_cnt++;
                last_rv_cyc = cyc;
                chk("rv_expected", int'(q_rv.size() > 0), 1);
                if (q_rv.size() > 0) begin
                    e = q_rv.pop_front();
                    chk("rv_cycle", cyc, e.cyc);
                    chk("rv_both", int'(rv_a && rv_b), 1);
                    chk("leds_a", leds_a, e.a);
                    chk("leds_b", leds_b, e.b);
                    chk("busy_at_valid", busy_a, 0);
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(logic [3:0] m, int hold);
        btn = m;
        tick(hold);
        btn = '0;
        tick(14);
    endtask

    task automatic chk_zero(string name);
        chk(name, {en_a, addr_a, leds_a, rv_a, busy_a, en_b, addr_b, leds_b, rv_b, busy_b}, 0);
    endtask

    int  n0, r0;
    bit  found;

    initial begin
        tick(3);
        chk_zero("reset_outputs");
        rst_n = 1'b1;
        tick(2);

        // 1: single press of btn[0]
        n0 = en_cnt;
        press(4'b0001, 10);
        chk("t1_reads", en_cnt - n0, 1);
        chk("t1_addr", last_addr_a, 0);
        chk("t1_leds", leds_a, 4'hA);
        chk("t1_latency", last_rv_cyc - last_en_cyc, 3);

        // 2: simultaneous presses, lowest index wins
        n0 = en_cnt;
        press(4'b0110, 10);
        chk("t2_reads", en_cnt - n0, 1);
        chk("t2_addr", last_addr_a, 1);
        chk("t2_leds", leds_a, 4'hB);

        // 3: btn[3] press lands in WAIT of a btn[0] read and is dropped
        n0 = en_cnt;
        btn = 4'b0001;
        tick(2);
        btn = 4'b1001;
        tick(8);
        btn = '0;
        tick(14);
        chk("t3_reads", en_cnt - n0, 1);
        chk("t3_addr", last_addr_a, 0);
        press(4'b1000, 10);
        chk("t3_reads2", en_cnt - n0, 2);
        chk("t3_leds", leds_a, 4'h9);

        // 4: glitch shorter than the debounce window, then a just-long-enough press
        n0 = en_cnt;
        press(4'b0010, 3);
        chk("t4_glitch_reads", en_cnt - n0, 0);
        chk("t4_glitch_leds", leds_a, 4'h9);
        press(4'b0010, 5);
        chk("t4_reads", en_cnt - n0, 1);
        chk("t4_leds", leds_a, 4'hB);

        // 5: reset during WAIT aborts the read; held button re-presses after reset
        btn = 4'b0001;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1);
            if (busy_a && !en_a) found = 1'b1;
        end
        chk("t5_wait_reached", found, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("t5_reset_outputs");
        r0 = rv_cnt;
        n0 = en_cnt;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("t5_no_valid", rv_cnt - r0, 0);
        tick(12);
        chk("t5_repress", en_cnt - n0, 1);
        btn = '0;
        tick(14);

        // 6: address wrap on the ADDR_BASE=14 instance
        press(4'b1000, 10);
        chk("t6_addr_b", last_addr_b, 1);
        chk("t6_leds_b", leds_b, 4'hB);

        // Random phase with occasional resets
        repeat (80) begin
            btn = 4'($urandom_range(0, 15));
            tick($urandom_range(1, 12));
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
        end
        btn = '0;
        tick(20);
        chk("en_queue_drained", q_en.size(), 0);
        chk("rv_queue_drained", q_rv.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
